// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and fixed byte values.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HGAP,
        ST_DATA,
        ST_DGAP
    } arb_state_t;

    localparam logic [7:0] UART_TAG_BASE  = 8'hA0;
    localparam logic [7:0] UART_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester at or after rrPtr, modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  reqValid,
    input  logic [ID_WIDTH-1:0] rrPtr,
    output logic [ID_WIDTH-1:0] winner,
    output logic                found
);

    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

    logic [ID_WIDTH-1:0] cand [NUM_REQ];

    // cand[gi] is the requester index gi positions after the pointer
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [ID_WIDTH:0] sum;
        assign sum = {1'b0, rrPtr} + (ID_WIDTH+1)'(gi);
        assign cand[gi] = (sum >= NUM_REQ_W) ? ID_WIDTH'(sum - NUM_REQ_W) : sum[ID_WIDTH-1:0];
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (reqValid[cand[k]]) begin
                winner = cand[k];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx between NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to prefix each data frame with a tag frame (8'hA0 | grantId).
import uart_pkg::*;

module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    reqValid,
    input  logic [8*NUM_REQ-1:0]  reqData,
    output logic [NUM_REQ-1:0]    reqReady,
    output logic                  txEnable,
    output logic [7:0]            uartInByte,
    input  logic                  uartTxDone,
    output logic                  busy,
    output logic [ID_WIDTH-1:0]   grantId
);

    arb_state_t          state_reg;
    logic [ID_WIDTH-1:0] rr_ptr_reg;
    logic [7:0]          byte_reg;
    logic [ID_WIDTH-1:0] grant_id_reg;
    logic                tx_enable_reg;
    logic [7:0]          out_byte_reg;
    logic                busy_reg;

    logic [ID_WIDTH-1:0] winner;
    logic                found;
    logic [ID_WIDTH-1:0] rr_ptr_next;
    logic [7:0]          req_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = reqData[8*gi +: 8];
    end

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .reqValid (reqValid),
        .rrPtr    (rr_ptr_reg),
        .winner   (winner),
        .found    (found)
    );

    assign rr_ptr_next = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    // Acceptance is combinational so the producer sees it in the same cycle it is chosen
    always_comb begin
        reqReady = '0;
        if (state_reg == ST_IDLE && found && !reset)
            reqReady[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            byte_reg      <= UART_IDLE_BYTE;
            grant_id_reg  <= '0;
            tx_enable_reg <= 1'b0;
            out_byte_reg  <= UART_IDLE_BYTE;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (found) begin
                        byte_reg      <= req_bytes[winner];
                        grant_id_reg  <= winner;
                        rr_ptr_reg    <= rr_ptr_next;
                        busy_reg      <= 1'b1;
                        tx_enable_reg <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        state_reg     <= ST_HDR;
                        out_byte_reg  <= UART_TAG_BASE | 8'(winner);
`else
                        state_reg     <= ST_DATA;
                        out_byte_reg  <= req_bytes[winner];
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                ST_HDR: begin
                    if (uartTxDone) begin
                        state_reg     <= ST_HGAP;
                        tx_enable_reg <= 1'b0;
                    end
                end
                ST_HGAP: begin
                    state_reg     <= ST_DATA;
                    tx_enable_reg <= 1'b1;
                    out_byte_reg  <= byte_reg;
                end
`endif
                ST_DATA: begin
                    // UartTx restarts only while txEnable is low, so the drop here is mandatory
                    out_byte_reg <= byte_reg;
                    if (uartTxDone) begin
                        state_reg     <= ST_DGAP;
                        tx_enable_reg <= 1'b0;
                    end
                end
                ST_DGAP: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    tx_enable_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign txEnable   = tx_enable_reg;
    assign uartInByte = out_byte_reg;
    assign busy       = busy_reg;
    assign grantId    = grant_id_reg;

endmodule
